mem_access_sequencer: RTL and testbench
=======================================

// Module: mem_access_sequencer
// PURPOSE
//  Sequences every data-memory transaction the control unit requests via MOV/RW/typeData.
//  Drives the word-wide data RAM with fixed wait states and byte enables.
//  Splits doubleword transfers into two word beats.
//  Returns MOC to the control unit. Sits between controlUnit/MAR/MDR and the RAM.
// PARAMETERS
//  ADDR_W    9  byte-address width (512-byte RAM)
//  WAIT_CYC  2  RAM access cycles per beat; legal range >=1
// PORTS
//  CLK        in   1       system clock, rising edge
//  CLR        in   1       reset, asynchronous, active-low
//  MOV        in   1       memory operation valid (level) from control unit
//  RW         in   1       1=read, 0=write
//  typeData   in   2       00 byte, 01 halfword, 10 word, 11 doubleword
//  addr       in   ADDR_W  byte address (from MAR)
//  wdata      in   32      write data, low word (from MDR)
//  wdata_hi   in   32      write data, high word (doubleword only)
//  MOC        out  1       memory operation complete
//  abort      out  1       misaligned access flagged; valid while MOC=1
//  rdata      out  32      read data, zero-extended; low word for doubleword
//  rdata_hi   out  32      doubleword high word
//  ram_en     out  1       RAM select
//  ram_rw     out  1       1=read, 0=write
//  ram_be     out  4       byte-lane enables; lane i = bits 8i+7:8i
//  ram_addr   out  ADDR_W-2 word address
//  ram_wdata  out  32      lane-aligned write data
//  ram_rdata  in   32      RAM read word; valid in last cycle of a beat
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, beat and wait counters 0. Applies asynchronously, also mid-access.
//    A write beat in flight may have partially updated the RAM.
//  States: IDLE, ACCESS, DONE, FAULT.
//  IDLE, MOV=1 sampled at edge k:
//    Latch addr, RW, typeData, wdata, wdata_hi. Later changes to these inputs are ignored until IDLE.
//    Check alignment: halfword addr[0]=0; word addr[1:0]=0; doubleword addr[2:0]=0.
//    Misaligned -> FAULT: MOC=1, abort=1, no RAM cycle.
//    Aligned -> ACCESS.
//  ACCESS: ram_en=1 for exactly WAIT_CYC cycles per beat; ram_addr/ram_be/ram_wdata held stable.
//    Read: capture ram_rdata on the final cycle of the beat.
//    Doubleword: beat 0 at addr, beat 1 at addr+4.
//      ram_en stays high across the beats: 2*WAIT_CYC consecutive cycles.
//  Byte: ram_be=1<<addr[1:0]; write data replicated to all lanes.
//    Read returns the selected lane, zero-extended.
//  Halfword: ram_be=addr[1]?1100:0011; read returns selected half, zero-extended.
//  Word/doubleword: ram_be=1111.
//  DONE: MOC=1, rdata/rdata_hi stable. Held while MOV=1; MOV=0 -> IDLE, MOC=0 next cycle.
//  FAULT: same MOC exit rule as DONE. abort=1 throughout. rdata unchanged.
//  Latency, MOV seen at edge k: ram_en high cycles k+1..k+WAIT_CYC. MOC high from k+1+WAIT_CYC.
//    Doubleword: MOC from k+1+2*WAIT_CYC. Fault: MOC from k+1.
//  MOV dropped during ACCESS: access still completes; MOC pulses exactly one cycle, then IDLE.
//  New request needs MOV low for at least one cycle after MOC; back-to-back transfers are not supported.
//  ram_rw = latched RW during ACCESS; 0 elsewhere.
//  Doubleword addr+4 never crosses the top of memory, because of 8-byte alignment.
// STRUCTURE
//  Shared package mem_pkg: typeData encodings (TD_BYTE..TD_DWORD) and FSM state enum.
//  One sub-module, mem_lane_align: combinational byte-enable generation, write replication,
//    read extraction/zero-extension.
//  Wait counter width $clog2(WAIT_CYC+1); beat counter is 1 bit.
// TESTING
//  Byte read at addr 0x005, RAM word 0xAABBCCDD -> ram_be=0010, rdata=0x000000CC, MOC at k+3.
//  Halfword write 0x1234 at 0x00A -> ram_be=1100, ram_wdata[31:16]=0x1234; MOC held until MOV=0.
//  Doubleword read at 0x010, RAM 0x11111111/0x22222222 -> ram_addr 4 then 5.
//    rdata=0x11111111, rdata_hi=0x22222222, MOC at k+5.
//  Word read at 0x006 -> abort=1, MOC=1 at k+1, ram_en never asserted.
//  CLR low during doubleword beat 1 -> all outputs 0 immediately; next word request completes normally.
//  MOV dropped during ACCESS -> single-cycle MOC pulse, return to IDLE.

Source files
------------

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared encodings for the data-memory access sequencer
// Purpose: typeData encodings, sequencer FSM states and the alignment check.
// Ports: none (package).
package mem_pkg;

  localparam logic [1:0] TD_BYTE  = 2'b00;
  localparam logic [1:0] TD_HALF  = 2'b01;
  localparam logic [1:0] TD_WORD  = 2'b10;
  localparam logic [1:0] TD_DWORD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_DONE   = 2'b10,
    ST_FAULT  = 2'b11
  } state_e;

  // Natural alignment: halfword on 2, word on 4, doubleword on 8 bytes.
  function automatic logic is_misaligned(input logic [1:0] td, input logic [2:0] a);
    case (td)
      TD_HALF:  return a[0];
      TD_WORD:  return |a[1:0];
      TD_DWORD: return |a[2:0];
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - byte-lane enables, write replication, read extraction
// Purpose: combinational lane steering between the CPU view and the 32-bit RAM word.
// Ports:
//   td_i        in  2   transfer size (TD_*)
//   addr_lo_i   in  2   byte offset within the word
//   wdata_i     in  32  CPU write data (right-justified)
//   rdata_raw_i in  32  RAM word
//   be_o        out 4   byte-lane enables
//   wdata_o     out 32  write data replicated across lanes
//   rdata_o     out 32  selected lane(s), zero-extended
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  td_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_raw_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  always_comb begin
    be_o    = 4'b1111;
    wdata_o = wdata_i;
    rdata_o = rdata_raw_i;
    case (td_i)
      TD_BYTE: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
        case (addr_lo_i)
          2'd0:    rdata_o = {24'h0, rdata_raw_i[7:0]};
          2'd1:    rdata_o = {24'h0, rdata_raw_i[15:8]};
          2'd2:    rdata_o = {24'h0, rdata_raw_i[23:16]};
          default: rdata_o = {24'h0, rdata_raw_i[31:24]};
        endcase
      end
      TD_HALF: begin
        be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = {16'h0, (addr_lo_i[1] ? rdata_raw_i[31:16] : rdata_raw_i[15:0])};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_sequencer.sv
// rtl/mem_access_sequencer.sv - data-memory transaction sequencer with wait states
// Purpose: accepts MOV/RW/typeData requests, runs WAIT_CYC-cycle RAM beats (two for
//   doublewords), flags misaligned requests, and returns MOC to the control unit.
// Ports:
//   CLK, CLR                 clock, async active-low reset
//   MOV, RW, typeData        request valid (level), direction (1=read), size
//   addr, wdata, wdata_hi    byte address, low/high write words
//   MOC, abort               completion, misalignment flag
//   rdata, rdata_hi          read data (zero-extended), doubleword high word
//   ram_en, ram_rw, ram_be   RAM select, direction, byte-lane enables
//   ram_addr, ram_wdata      RAM word address, lane-aligned write data
//   ram_rdata                RAM read word, valid in the last cycle of a beat
module mem_access_sequencer
  import mem_pkg::*;
#(
  parameter int ADDR_W   = 9,
  parameter int WAIT_CYC = 2
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              MOV,
  input  logic              RW,
  input  logic [1:0]        typeData,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  input  logic [31:0]       wdata_hi,
  output logic              MOC,
  output logic              abort,
  output logic [31:0]       rdata,
  output logic [31:0]       rdata_hi,
  output logic              ram_en,
  output logic              ram_rw,
  output logic [3:0]        ram_be,
  output logic [ADDR_W-3:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  localparam int WW = $clog2(WAIT_CYC + 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_CYC - 1);

  state_e            state_q;
  logic [1:0]        td_q;
  logic [1:0]        addr_lo_q;
  logic [31:0]       wdata_hi_q;
  logic              beat_q;
  logic [WW-1:0]     wait_q;
  logic              moc_q;
  logic              abort_q;
  logic [31:0]       rdata_q;
  logic [31:0]       rdata_hi_q;
  logic              ram_en_q;
  logic              ram_rw_q;
  logic [3:0]        ram_be_q;
  logic [ADDR_W-3:0] ram_addr_q;
  logic [31:0]       ram_wdata_q;

  // In IDLE the lane logic looks at the live request so the first beat can be
  // issued on the accepting edge; afterwards it works from the latched copy.
  logic        in_idle;
  logic [1:0]  lane_td;
  logic [1:0]  lane_addr_lo;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  logic [31:0] lane_rdata;

  assign in_idle      = (state_q == ST_IDLE);
  assign lane_td      = in_idle ? typeData  : td_q;
  assign lane_addr_lo = in_idle ? addr[1:0] : addr_lo_q;

  mem_lane_align u_lane (
    .td_i        (lane_td),
    .addr_lo_i   (lane_addr_lo),
    .wdata_i     (wdata),
    .rdata_raw_i (ram_rdata),
    .be_o        (lane_be),
    .wdata_o     (lane_wdata),
    .rdata_o     (lane_rdata)
  );

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state_q     <= ST_IDLE;
      td_q        <= TD_BYTE;
      addr_lo_q   <= '0;
      wdata_hi_q  <= '0;
      beat_q      <= 1'b0;
      wait_q      <= '0;
      moc_q       <= 1'b0;
      abort_q     <= 1'b0;
      rdata_q     <= '0;
      rdata_hi_q  <= '0;
      ram_en_q    <= 1'b0;
      ram_rw_q    <= 1'b0;
      ram_be_q    <= '0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (MOV) begin
            if (is_misaligned(typeData, addr[2:0])) begin
              state_q <= ST_FAULT;
              moc_q   <= 1'b1;
              abort_q <= 1'b1;
            end else begin
              state_q     <= ST_ACCESS;
              td_q        <= typeData;
              addr_lo_q   <= addr[1:0];
              wdata_hi_q  <= wdata_hi;
              beat_q      <= 1'b0;
              wait_q      <= '0;
              ram_en_q    <= 1'b1;
              ram_rw_q    <= RW;
              ram_be_q    <= lane_be;
              ram_addr_q  <= addr[ADDR_W-1:2];
              ram_wdata_q <= lane_wdata;
            end
          end
        end

        ST_ACCESS: begin
          if (wait_q == WAIT_LAST) begin
            // Final cycle of the beat: RAM read data is valid now.
            if (ram_rw_q) begin
              if (td_q == TD_DWORD && beat_q) rdata_hi_q <= ram_rdata;
              else                            rdata_q    <= lane_rdata;
            end
            if (td_q == TD_DWORD && !beat_q) begin
              // Second beat follows immediately; ram_en stays high.
              beat_q      <= 1'b1;
              wait_q      <= '0;
              ram_addr_q  <= ram_addr_q + (ADDR_W-2)'(1);
              ram_wdata_q <= wdata_hi_q;
            end else begin
              state_q     <= ST_DONE;
              moc_q       <= 1'b1;
              beat_q      <= 1'b0;
              wait_q      <= '0;
              ram_en_q    <= 1'b0;
              ram_rw_q    <= 1'b0;
              ram_be_q    <= '0;
              ram_addr_q  <= '0;
              ram_wdata_q <= '0;
            end
          end else begin
            wait_q <= wait_q + WW'(1);
          end
        end

        ST_DONE, ST_FAULT: begin
          if (!MOV) begin
            state_q <= ST_IDLE;
            moc_q   <= 1'b0;
            abort_q <= 1'b0;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign MOC       = moc_q;
  assign abort     = abort_q;
  assign rdata     = rdata_q;
  assign rdata_hi  = rdata_hi_q;
  assign ram_en    = ram_en_q;
  assign ram_rw    = ram_rw_q;
  assign ram_be    = ram_be_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;

endmodule

// File: tb/tb_mem_access_sequencer.sv
// tb/tb_mem_access_sequencer.sv - self-checking bench for mem_access_sequencer
module tb_mem_access_sequencer;

  logic        CLK = 1'b0;
  logic        CLR = 1'b0;
  logic        MOV = 1'b0;
  logic        RW = 1'b0;
  logic [1:0]  typeData = 2'b00;
  logic [8:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] wdata_hi = '0;
  logic        MOC;
  logic        abort;
  logic [31:0] rdata;
  logic [31:0] rdata_hi;
  logic        ram_en;
  logic        ram_rw;
  logic [3:0]  ram_be;
  logic [6:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  int asserts = 0;
  int fails = 0;

  logic [31:0] mem [0:127];

  typedef struct {
    int          moc_cyc;
    int          en_cnt;
    logic        abort;
    logic [31:0] rdata;
    logic [31:0] rdata_hi;
    logic [3:0]  be;
    logic [6:0]  a0;
    logic [6:0]  a1;
    logic [31:0] wd0;
  } exp_t;

  exp_t sb[$];

  always #5 CLK = ~CLK;

  mem_access_sequencer #(.ADDR_W(9), .WAIT_CYC(2)) dut (
    .CLK       (CLK),
    .CLR       (CLR),
    .MOV       (MOV),
    .RW        (RW),
    .typeData  (typeData),
    .addr      (addr),
    .wdata     (wdata),
    .wdata_hi  (wdata_hi),
    .MOC       (MOC),
    .abort     (abort),
    .rdata     (rdata),
    .rdata_hi  (rdata_hi),
    .ram_en    (ram_en),
    .ram_rw    (ram_rw),
    .ram_be    (ram_be),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  assign ram_rdata = mem[ram_addr];

  always @(posedge CLK) begin
    if (ram_en && !ram_rw) begin
      for (int b = 0; b < 4; b++)
        if (ram_be[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
    end
  end

  // Observed transaction, filled by run_txn.
  int          o_moc_cyc, o_en_cnt;
  logic        o_abort, o_hold_ok, o_moc_after;
  logic [31:0] o_rdata, o_rdata_hi, o_wd0;
  logic [3:0]  o_be;
  logic [6:0]  o_a0, o_a1;

  // Drives one request; cycle n = the cycle after accepting edge k + n - 1.
  // Request inputs are scrambled after acceptance to prove they were latched.
  task automatic run_txn(input logic rw, input logic [1:0] td, input logic [8:0] a,
                         input logic [31:0] wd, input logic [31:0] wdh, input int hold);
    int cyc;
    @(negedge CLK);
    MOV = 1'b1; RW = rw; typeData = td; addr = a; wdata = wd; wdata_hi = wdh;
    cyc = 0; o_moc_cyc = -1; o_en_cnt = 0; o_hold_ok = 1'b1;
    while (o_moc_cyc < 0 && cyc < 40) begin
      @(negedge CLK);
      cyc++;
      if (cyc == 1) begin
        RW = ~rw; typeData = ~td; addr = ~a; wdata = 32'hDEAD0000; wdata_hi = 32'h0BAD0BAD;
      end
      if (ram_en) begin
        if (o_en_cnt == 0) begin o_a0 = ram_addr; o_be = ram_be; o_wd0 = ram_wdata; end
        o_a1 = ram_addr;
        o_en_cnt++;
      end
      if (MOC) begin
        o_moc_cyc = cyc; o_abort = abort; o_rdata = rdata; o_rdata_hi = rdata_hi;
      end
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge CLK);
      if (!MOC || rdata !== o_rdata) o_hold_ok = 1'b0;
    end
    MOV = 1'b0;
    @(negedge CLK);
    o_moc_after = MOC;
  endtask

  // Pops the oldest expectation and compares it with the observed transaction.
  task automatic check_txn(input string name);
    exp_t e;
    if (sb.size() == 0) begin
      asserts++; fails++;
      $display("FAIL %s scoreboard empty", name);
      return;
    end
    e = sb.pop_front();
    asserts++; if (o_moc_cyc !== e.moc_cyc) begin fails++; $display("FAIL %s moc_cycle got %0d want %0d", name, o_moc_cyc, e.moc_cyc); end
    asserts++; if (o_en_cnt !== e.en_cnt) begin fails++; $display("FAIL %s ram_en_cycles got %0d want %0d", name, o_en_cnt, e.en_cnt); end
    asserts++; if (o_abort !== e.abort) begin fails++; $display("FAIL %s abort got %b want %b", name, o_abort, e.abort); end
    asserts++; if (o_rdata !== e.rdata) begin fails++; $display("FAIL %s rdata got %h want %h", name, o_rdata, e.rdata); end
    asserts++; if (o_moc_after !== 1'b0) begin fails++; $display("FAIL %s moc_after_mov_low got %b want 0", name, o_moc_after); end
    if (e.en_cnt > 0) begin
      asserts++; if (o_be !== e.be) begin fails++; $display("FAIL %s ram_be got %b want %b", name, o_be, e.be); end
      asserts++; if (o_a0 !== e.a0) begin fails++; $display("FAIL %s ram_addr_first got %h want %h", name, o_a0, e.a0); end
      asserts++; if (o_a1 !== e.a1) begin fails++; $display("FAIL %s ram_addr_last got %h want %h", name, o_a1, e.a1); end
    end
  endtask

  task automatic test_reset;
    CLR = 1'b0;
    repeat (2) @(negedge CLK);
    asserts++; if ({MOC, abort, ram_en, ram_rw} !== 4'b0) begin fails++; $display("FAIL reset ctrl got %b want 0000", {MOC, abort, ram_en, ram_rw}); end
    asserts++; if ({rdata, rdata_hi, ram_wdata} !== 96'h0) begin fails++; $display("FAIL reset data got %h want 0", {rdata, rdata_hi, ram_wdata}); end
    asserts++; if ({ram_be, ram_addr} !== 11'h0) begin fails++; $display("FAIL reset be_addr got %h want 0", {ram_be, ram_addr}); end
    CLR = 1'b1;
  endtask

  task automatic test_byte_read;
    mem[1] = 32'hAABBCCDD;
    sb.push_back('{3, 2, 1'b0, 32'h000000CC, 32'h0, 4'b0010, 7'd1, 7'd1, 32'h0});
    run_txn(1'b1, 2'b00, 9'h005, 32'h0, 32'h0, 0);
    check_txn("byte_read");
  endtask

  task automatic test_half_write;
    mem[2] = 32'hDEADBEEF;
    sb.push_back('{3, 2, 1'b0, 32'h000000CC, 32'h0, 4'b1100, 7'd2, 7'd2, 32'h0});
    run_txn(1'b0, 2'b01, 9'h00A, 32'h00001234, 32'h0, 3);
    check_txn("half_write");
    asserts++; if (o_wd0[31:16] !== 16'h1234) begin fails++; $display("FAIL half_write ram_wdata_hi got %h want 1234", o_wd0[31:16]); end
    asserts++; if (o_hold_ok !== 1'b1) begin fails++; $display("FAIL half_write moc_held got %b want 1", o_hold_ok); end
    asserts++; if (mem[2] !== 32'h1234BEEF) begin fails++; $display("FAIL half_write ram_word got %h want 1234beef", mem[2]); end
  endtask

  task automatic test_misaligned;
    sb.push_back('{1, 0, 1'b1, 32'h000000CC, 32'h0, 4'b0000, 7'd0, 7'd0, 32'h0});
    run_txn(1'b1, 2'b10, 9'h006, 32'h0, 32'h0, 2);
    check_txn("word_misaligned");
    asserts++; if (o_hold_ok !== 1'b1) begin fails++; $display("FAIL word_misaligned moc_held got %b want 1", o_hold_ok); end
    sb.push_back('{1, 0, 1'b1, 32'h000000CC, 32'h0, 4'b0000, 7'd0, 7'd0, 32'h0});
    run_txn(1'b1, 2'b01, 9'h003, 32'h0, 32'h0, 0);
    check_txn("half_misaligned");
  endtask

  task automatic test_dword_read;
    mem[4] = 32'h11111111;
    mem[5] = 32'h22222222;
    sb.push_back('{5, 4, 1'b0, 32'h11111111, 32'h22222222, 4'b1111, 7'd4, 7'd5, 32'h0});
    run_txn(1'b1, 2'b11, 9'h010, 32'h0, 32'h0, 0);
    check_txn("dword_read");
    asserts++; if (o_rdata_hi !== 32'h22222222) begin fails++; $display("FAIL dword_read rdata_hi got %h want 22222222", o_rdata_hi); end
  endtask

  task automatic test_byte_write_readback;
    sb.push_back('{3, 2, 1'b0, 32'h11111111, 32'h0, 4'b1000, 7'd4, 7'd4, 32'h0});
    run_txn(1'b0, 2'b00, 9'h013, 32'h000000F7, 32'h0, 0);
    check_txn("byte_write");
    asserts++; if (o_wd0 !== 32'hF7F7F7F7) begin fails++; $display("FAIL byte_write ram_wdata got %h want f7f7f7f7", o_wd0); end
    sb.push_back('{3, 2, 1'b0, 32'h000000F7, 32'h0, 4'b1000, 7'd4, 7'd4, 32'h0});
    run_txn(1'b1, 2'b00, 9'h013, 32'h0, 32'h0, 0);
    check_txn("byte_readback");
    asserts++; if (mem[4] !== 32'hF7111111) begin fails++; $display("FAIL byte_write ram_word got %h want f7111111", mem[4]); end
  endtask

  task automatic test_reset_mid_access;
    mem[7] = 32'hCAFEF00D;
    @(negedge CLK);
    MOV = 1'b1; RW = 1'b1; typeData = 2'b11; addr = 9'h018;
    repeat (3) @(negedge CLK);
    asserts++; if (!(ram_en === 1'b1 && ram_addr === 7'd7)) begin fails++; $display("FAIL reset_mid beat1 got en=%b addr=%h want en=1 addr=07", ram_en, ram_addr); end
    #1 CLR = 1'b0;
    #1;
    asserts++; if ({MOC, abort, ram_en, ram_rw, ram_be, ram_addr} !== 15'h0) begin fails++; $display("FAIL reset_mid ctrl got %h want 0", {MOC, abort, ram_en, ram_rw, ram_be, ram_addr}); end
    asserts++; if ({rdata, rdata_hi, ram_wdata} !== 96'h0) begin fails++; $display("FAIL reset_mid data got %h want 0", {rdata, rdata_hi, ram_wdata}); end
    MOV = 1'b0;
    @(negedge CLK);
    CLR = 1'b1;
    sb.push_back('{3, 2, 1'b0, 32'hCAFEF00D, 32'h0, 4'b1111, 7'd7, 7'd7, 32'h0});
    run_txn(1'b1, 2'b10, 9'h01C, 32'h0, 32'h0, 0);
    check_txn("word_after_reset");
  endtask

  task automatic test_mov_drop;
    int moc_hi, moc_at;
    mem[8] = 32'h0;
    moc_hi = 0; moc_at = -1;
    @(negedge CLK);
    MOV = 1'b1; RW = 1'b0; typeData = 2'b10; addr = 9'h020; wdata = 32'h5A5AA5A5;
    @(negedge CLK);
    MOV = 1'b0;
    for (int c = 2; c <= 8; c++) begin
      @(negedge CLK);
      if (MOC) begin moc_hi++; if (moc_at < 0) moc_at = c; end
    end
    asserts++; if (moc_hi !== 1) begin fails++; $display("FAIL mov_drop moc_cycles got %0d want 1", moc_hi); end
    asserts++; if (moc_at !== 3) begin fails++; $display("FAIL mov_drop moc_cycle got %0d want 3", moc_at); end
    asserts++; if (mem[8] !== 32'h5A5AA5A5) begin fails++; $display("FAIL mov_drop ram_word got %h want 5a5aa5a5", mem[8]); end
    sb.push_back('{3, 2, 1'b0, 32'h5A5AA5A5, 32'h0, 4'b1111, 7'd8, 7'd8, 32'h0});
    run_txn(1'b1, 2'b10, 9'h020, 32'h0, 32'h0, 0);
    check_txn("read_after_drop");
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 32'h0;
    test_reset;
    test_byte_read;
    test_half_write;
    test_misaligned;
    test_dword_read;
    test_byte_write_readback;
    test_reset_mid_access;
    test_mov_drop;
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
